// File: rtl/spi_master.sv
// rtl/spi_master.sv - single chip-select SPI initiator, CPOL=0, MSB first
//
// Purpose: serialises one DATA_W-bit frame per start request onto mosi while
// capturing miso. sclk is derived from clk by counting HALF_DIV cycles per
// half-period. mosi changes only on the edge that drives sclk low.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   start    frame request, accepted only while idle
//   tx_data  frame to send, sampled in the accepting cycle
//   busy     high from the cycle after acceptance until frame end
//   done     one-cycle pulse at frame end, rx_data valid from this cycle
//   rx_data  last received frame
//   cs       chip select, active low
//   sclk     SPI clock, idles low
//   mosi     serial data out
//   miso     serial data in, synchronous to clk

`timescale 1ns/1ps

module spi_master #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    // Counter widths never drop to zero bits, even with HALF_DIV=1.
    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [HW-1:0] HMAX = HW'(HALF_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL
    } state_t;

    state_t            state;
    logic [HW-1:0]     hcnt;
    logic [BW-1:0]     bcnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              hwrap;

    // Last cycle of the current half-period.
    assign hwrap = (hcnt == HMAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            bcnt    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE) begin
                hcnt <= hwrap ? '0 : hcnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    cs   <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (start) begin
                        tx_sr <= tx_data;
                        cs    <= 1'b0;
                        mosi  <= tx_data[DATA_W-1];
                        busy  <= 1'b1;
                        hcnt  <= '0;
                        bcnt  <= '0;
                        state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (hwrap) begin
                        sclk  <= 1'b1;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // miso has had a full high phase to settle before capture.
                    if (hwrap) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        sclk  <= 1'b0;
                        if (bcnt == BMAX) begin
                            mosi  <= 1'b0;
                            state <= S_TRAIL;
                        end else begin
                            tx_sr <= tx_sr << 1;
                            mosi  <= tx_sr[DATA_W-2];
                            bcnt  <= bcnt + 1'b1;
                            state <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (hwrap) begin
                        sclk  <= 1'b1;
                        state <= S_HIGH;
                    end
                end
                S_TRAIL: begin
                    if (hwrap) begin
                        cs      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
